// File: rtl/al_accel_lpuctrl_if.sv
// Pixel-in and window-out valid/ready streams of the line pixel sequencer.
// slave: sequencer side; master: feeder/consumer side.
interface al_accel_lpuctrl_if #(
   parameter int DW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          win_valid;
   logic          win_ready;
   logic          win_last;

   modport slave (
      input  in_valid, in_data, win_ready,
      output in_ready, win_valid, win_last
   );

   modport master (
      output in_valid, in_data, win_ready,
      input  in_ready, win_valid, win_last
   );
endinterface

// File: rtl/al_accel_lpuctrl.sv
// Sequencer for the 3-tap line pixel register: builds per-row sliding
// windows from a raster stream and hands them to the MAC stage.
// Ports: clk/resetn, start/abort/cfg_*, pif (pixel in + window out),
// lpureg_* register pins, busy/done/cfg_err status.
// Option ACCEL_LPUCTRL_STALL_CNT_EN adds a 16-bit stall_cnt output.
module al_accel_lpuctrl #(
   parameter int DW    = 8,
   parameter int CNT_W = 10
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 abort,
   input  logic [CNT_W-1:0]     cfg_row_len,
   input  logic [CNT_W-1:0]     cfg_num_rows,
   al_accel_lpuctrl_if.slave    pif,
   output logic [DW-1:0]        lpureg_di_0,
   output logic [DW-1:0]        lpureg_di_1,
   output logic [DW-1:0]        lpureg_di_2,
   output logic                 lpureg_ld_wrn,
   output logic                 lpureg_enb,
   output logic                 busy,
   output logic                 done,
`ifdef ACCEL_LPUCTRL_STALL_CNT_EN
   output logic [15:0]          stall_cnt,
`endif
   output logic                 cfg_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [1:0]       state;
   logic [CNT_W-1:0] col;
   logic [CNT_W-1:0] row;
   logic [CNT_W-1:0] row_len_q;
   logic [CNT_W-1:0] num_rows_q;
   logic [DW-1:0]    s0;
   logic [DW-1:0]    s1;
   logic             win_valid_q;
   logic             win_last_q;
   logic             rdy;
   logic             accept;
   logic             load;
   logic             consume;
   logic             row_end;
   logic             last_row;
   logic             cfg_ok;
   logic             start_ok;

   always_comb begin
      rdy = 1'b0;
      unique case (state)
         S_FILL:  rdy = 1'b1;
         S_RUN:   rdy = !win_valid_q || pif.win_ready;
         default: rdy = 1'b0;
      endcase
   end

   assign accept   = pif.in_valid && rdy;
   assign load     = accept && (state == S_RUN);
   assign consume  = win_valid_q && pif.win_ready;
   assign row_end  = (col == row_len_q - ONE);
   assign last_row = (row == num_rows_q - ONE);
   assign cfg_ok   = (cfg_row_len >= CNT_W'(3)) &&
                     (cfg_num_rows >= ONE);
   assign start_ok = (state == S_IDLE) && start &&
                     cfg_ok && !abort;

   assign pif.in_ready  = rdy;
   assign pif.win_valid = win_valid_q;
   assign pif.win_last  = win_last_q;
   assign busy          = (state != S_IDLE);

   // Taps are driven only during a load so idle pins stay quiet.
   assign lpureg_enb    = load;
   assign lpureg_ld_wrn = load;
   assign lpureg_di_0   = load ? s1 : '0;
   assign lpureg_di_1   = load ? s0 : '0;
   assign lpureg_di_2   = load ? pif.in_data : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         col         <= '0;
         row         <= '0;
         row_len_q   <= '0;
         num_rows_q  <= '0;
         s0          <= '0;
         s1          <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         done        <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (abort) begin
            state       <= S_IDLE;
            col         <= '0;
            row         <= '0;
            s0          <= '0;
            s1          <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
         end else begin
            // A load always replaces a consumed (or empty) slot.
            if (load) begin
               win_valid_q <= 1'b1;
               win_last_q  <= row_end && last_row;
            end else if (consume) begin
               win_valid_q <= 1'b0;
               win_last_q  <= 1'b0;
            end
            unique case (state)
               S_IDLE: begin
                  if (start && cfg_ok) begin
                     row_len_q  <= cfg_row_len;
                     num_rows_q <= cfg_num_rows;
                     col        <= '0;
                     row        <= '0;
                     state      <= S_FILL;
                  end else if (start) begin
                     cfg_err <= 1'b1;
                  end
               end
               S_FILL: begin
                  if (accept) begin
                     s1  <= s0;
                     s0  <= pif.in_data;
                     col <= col + ONE;
                     if (col == ONE) state <= S_RUN;
                  end
               end
               S_RUN: begin
                  if (accept && row_end) begin
                     col   <= '0;
                     s0    <= '0;
                     s1    <= '0;
                     row   <= row + ONE;
                     state <= last_row ? S_DRAIN : S_FILL;
                  end else if (accept) begin
                     s1  <= s0;
                     s0  <= pif.in_data;
                     col <= col + ONE;
                  end
               end
               S_DRAIN: begin
                  if (consume) begin
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

`ifdef ACCEL_LPUCTRL_STALL_CNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt <= '0;
      end else if (start_ok) begin
         stall_cnt <= '0;
      end else if (win_valid_q && !pif.win_ready &&
                   stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_al_accel_lpuctrl.sv
// Randomized bench for al_accel_lpuctrl with a per-cycle reference model
// built from window indices and a queue of outstanding windows.
module tb_al_accel_lpuctrl;
   localparam int DW    = 8;
   localparam int CNT_W = 10;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] cfg_row_len = '0;
   logic [CNT_W-1:0] cfg_num_rows = '0;
   logic [DW-1:0]    di0, di1, di2;
   logic             ld_wrn, enb, busy, done, cfg_err;
`ifdef ACCEL_LPUCTRL_STALL_CNT_EN
   logic [15:0]      stall_cnt;
`endif

   al_accel_lpuctrl_if #(.DW(DW)) pif ();

   al_accel_lpuctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .abort        (abort),
      .cfg_row_len  (cfg_row_len),
      .cfg_num_rows (cfg_num_rows),
      .pif          (pif),
      .lpureg_di_0  (di0),
      .lpureg_di_1  (di1),
      .lpureg_di_2  (di2),
      .lpureg_ld_wrn(ld_wrn),
      .lpureg_enb   (enb),
      .busy         (busy),
      .done         (done),
`ifdef ACCEL_LPUCTRL_STALL_CNT_EN
      .stall_cnt    (stall_cnt),
`endif
      .cfg_err      (cfg_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit         m_active;
   int         m_rl, m_nr, m_total, m_k;
   logic [7:0] hist [0:4095];
   bit         pend [$];
   bit         m_done_nx, m_err_nx;
   int         m_stall;
   logic [23:0] loads [$];

   bit  wv, wl, rdy, acc, ld, lastc, was_act, legal;
   int  pos;
   logic [23:0] exp_di;

   always @(negedge clk) begin
      if (!resetn) begin
         chk("reset_outs",
             {busy, done, cfg_err, pif.win_valid, pif.win_last,
              pif.in_ready, enb, ld_wrn, di0, di1, di2}, 32'h0);
`ifdef ACCEL_LPUCTRL_STALL_CNT_EN
         chk("reset_stall", {16'h0, stall_cnt}, 32'h0);
`endif
         m_active = 0; m_k = 0; m_rl = 0; m_nr = 0; m_total = 0;
         pend.delete(); m_done_nx = 0; m_err_nx = 0; m_stall = 0;
      end else begin
         wv  = pend.size() > 0;
         wl  = wv ? pend[0] : 1'b0;
         pos = (m_rl > 0) ? (m_k % m_rl) : 0;
         rdy = m_active && (m_k < m_total) &&
               (pos < 2 || !wv || pif.win_ready);
         acc = pif.in_valid && rdy;
         ld  = acc && pos >= 2;
         exp_di = ld ? {hist[m_k-2], hist[m_k-1], pif.in_data} : 24'h0;
         chk("status", {busy, done, cfg_err},
             {m_active, m_done_nx, m_err_nx});
         chk("win", {pif.win_valid, pif.win_last}, {wv, wl});
         chk("in_ready", pif.in_ready, rdy);
         chk("load", {enb, ld_wrn}, {ld, ld});
         chk("di", {di0, di1, di2}, exp_di);
`ifdef ACCEL_LPUCTRL_STALL_CNT_EN
         chk("stall_cnt", {16'h0, stall_cnt}, m_stall);
`endif
         if (enb) loads.push_back({di0, di1, di2});
         // next-cycle model state
         was_act = m_active;
         legal = (cfg_row_len >= 3) && (cfg_num_rows >= 1);
         m_done_nx = 0;
         m_err_nx = 0;
         if (start && !was_act && legal && !abort) m_stall = 0;
         else if (wv && !pif.win_ready && m_stall < 65535) m_stall++;
         if (wv && pif.win_ready) begin
            lastc = pend.pop_front();
            if (lastc) begin
               m_done_nx = 1;
               m_active = 0;
            end
         end
         if (acc) begin
            hist[m_k] = pif.in_data;
            if (ld) pend.push_back(m_k == m_total - 1);
            m_k++;
         end
         if (abort) begin
            m_active = 0; pend.delete(); m_k = 0; m_done_nx = 0;
         end else if (start && !was_act) begin
            if (legal) begin
               m_active = 1;
               m_rl = int'(cfg_row_len);
               m_nr = int'(cfg_num_rows);
               m_total = m_rl * m_nr;
               m_k = 0;
            end else begin
               m_err_nx = 1;
            end
         end
      end
   end

   // ---------------- pixel feeder / consumer ----------------
   logic [7:0] pix [$];
   int  pidx = 0;
   bit  feed_en = 0;
   bit  took;
   int  vprob = 100;
   int  rprob = 100;
   int  rmode = 1;

   initial begin
      pif.in_valid = 0;
      pif.in_data = 0;
      pif.win_ready = 0;
   end

   always begin
      @(negedge clk);
      took = pif.in_valid && pif.in_ready;
      @(posedge clk);
      #1;
      if (took) pidx++;
      if (feed_en && pidx < pix.size()) begin
         pif.in_valid = ($urandom_range(0, 99) < vprob);
         pif.in_data = pix[pidx];
      end else begin
         pif.in_valid = 0;
         pif.in_data = 8'($urandom);
      end
      case (rmode)
         1: pif.win_ready = 1;
         2: pif.win_ready = 0;
         default: pif.win_ready = ($urandom_range(0, 99) < rprob);
      endcase
   end

   // ---------------- directed/random sequences ----------------
   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(int rl, int nr);
      cfg_row_len = CNT_W'(rl);
      cfg_num_rows = CNT_W'(nr);
      start = 1;
      cyc(1);
      start = 0;
   endtask

   task automatic load_pix(int n, int base, bit rnd);
      pix.delete();
      for (int i = 0; i < n; i++)
         pix.push_back(rnd ? 8'($urandom) : 8'(base + i));
      pidx = 0;
   endtask

   task automatic wait_done(int budget, string nm);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk(nm, seen, 1);
      cyc(1);
   endtask

   task automatic wait_wv(int budget, string nm);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (pif.win_valid) seen = 1;
      end
      chk(nm, seen, 1);
   endtask

   task automatic frame_abs(int rl, int nr, int base);
      feed_en = 0;
      cyc(2);
      load_pix(rl * nr, base, 0);
      loads.delete();
      feed_en = 1;
      pulse_start(rl, nr);
   endtask

   int rl, nr;

   initial begin
      cyc(3);
      resetn = 1;
      cyc(2);

      // single row 1..5, free-flowing
      vprob = 100; rmode = 1;
      frame_abs(5, 1, 1);
      wait_done(100, "t1_done");
      chk("t1_nloads", loads.size(), 3);
      if (loads.size() == 3) begin
         chk("t1_w0", loads[0], 24'h010203);
         chk("t1_w1", loads[1], 24'h020304);
         chk("t1_w2", loads[2], 24'h030405);
      end

      // same frame with consumer stall after the first window
      rmode = 2;
      frame_abs(5, 1, 1);
      wait_wv(50, "t2_wv");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_hold_rdy", {pif.in_ready, enb}, 0);
         chk("t2_hold_n", loads.size(), 1);
      end
      cyc(1);
      rmode = 1;
      wait_done(100, "t2_done");
      chk("t2_nloads", loads.size(), 3);
      if (loads.size() == 3) begin
         chk("t2_w0", loads[0], 24'h010203);
         chk("t2_w2", loads[2], 24'h030405);
      end

      // two rows, random handshakes
      vprob = 70; rmode = 0; rprob = 60;
      frame_abs(4, 2, 10);
      wait_done(300, "t3_done");
      chk("t3_nloads", loads.size(), 4);
      if (loads.size() == 4) begin
         chk("t3_w0", loads[0], 24'h0a0b0c);
         chk("t3_w1", loads[1], 24'h0b0c0d);
         chk("t3_w2", loads[2], 24'h0e0f10);
         chk("t3_w3", loads[3], 24'h0f1011);
      end

      // illegal configurations
      feed_en = 0;
      pulse_start(2, 1);
      @(negedge clk);
      chk("t4_err_rl", {cfg_err, busy, pif.in_ready}, 3'b100);
      cyc(2);
      pulse_start(5, 0);
      @(negedge clk);
      chk("t4_err_nr", {cfg_err, busy, pif.in_ready}, 3'b100);
      cyc(2);

      // abort, then reset, mid-frame followed by a 3x1 frame
      for (int pass = 0; pass < 2; pass++) begin
         vprob = 100; rmode = 1;
         frame_abs(4, 3, 40);
         cyc(5);
         if (pass == 0) begin
            abort = 1; cyc(1); abort = 0;
         end else begin
            resetn = 0; cyc(2); resetn = 1;
         end
         feed_en = 0;
         cyc(2);
         @(negedge clk);
         chk("t5_idle", {busy, pif.win_valid}, 0);
         cyc(1);
         frame_abs(3, 1, 7);
         wait_done(100, "t5_done");
         chk("t5_nloads", loads.size(), 1);
         if (loads.size() == 1) chk("t5_w0", loads[0], 24'h070809);
      end

`ifdef ACCEL_LPUCTRL_STALL_CNT_EN
      rmode = 2;
      frame_abs(3, 1, 20);
      wait_wv(50, "t7_wv");
      repeat (6) @(negedge clk);
      chk("t7_stall6", {16'h0, stall_cnt}, 6);
      cyc(1);
      rmode = 1;
      wait_done(100, "t7_done");
      frame_abs(3, 1, 30);
      @(negedge clk);
      chk("t7_clear", {16'h0, stall_cnt}, 0);
      cyc(1);
      wait_done(100, "t7_done2");
`endif

      // randomized frames
      for (int f = 0; f < 12; f++) begin
         rl = $urandom_range(3, 9);
         nr = $urandom_range(1, 4);
         vprob = $urandom_range(30, 100);
         rprob = $urandom_range(30, 100);
         rmode = 0;
         feed_en = 0;
         cyc(2);
         load_pix(rl * nr, 0, 1);
         feed_en = 1;
         pulse_start(rl, nr);
         if (f == 3) begin
            cyc(4);
            pulse_start(2, 0);
         end
         if (f == 7) begin
            cyc($urandom_range(3, 12));
            abort = 1; cyc(1); abort = 0;
            feed_en = 0;
            cyc(3);
            @(negedge clk);
            chk("rnd_abort_idle", busy, 0);
            cyc(1);
         end else begin
            wait_done(3000, "rnd_done");
         end
      end
      feed_en = 0;
      cyc(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/al_accel_lpuctrl.md
Name: al_accel_lpuctrl

Overview:
Sequencer for the accelerator's 3-tap line pixel register (three DW-bit taps, with load-enable and clock-enable controls). Accepts a raster pixel stream over valid/ready and assembles 3-pixel sliding windows per row. Drives the register's data/load/enable pins, then presents the registered window to the compute stage via a valid/ready handshake. Sits between the SoC-side pixel feeder and the accelerator MAC datapath.

Parameters:
DW, 8, pixel width; must equal the tap width of the line pixel register
CNT_W, 10, width of row-length and row-count configuration and counters

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin a frame using cfg_* values
abort  in  1  synchronous abort; return to IDLE
cfg_row_len  in  CNT_W  pixels per row; minimum legal value 3
cfg_num_rows  in  CNT_W  rows per frame; minimum legal value 1
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_data  in  DW  pixel
lpureg_di_0  out  DW  oldest tap to register
lpureg_di_1  out  DW  middle tap
lpureg_di_2  out  DW  newest tap (= in_data)
lpureg_ld_wrn  out  1  load strobe to register
lpureg_enb  out  1  enable to register
win_valid  out  1  register output holds an unconsumed window
win_ready  in  1  consumer takes window
win_last  out  1  qualifies win_valid: last window of frame
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse: frame complete
cfg_err  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset (async, resetn=0): state=IDLE; col, row, s0, s1 = 0; all outputs 0.
- States: IDLE, FILL, RUN, DRAIN.
- IDLE: in_ready=0. start with cfg_row_len>=3 and cfg_num_rows>=1 latches cfg, clears col/row, goes to FILL. start with illegal cfg pulses cfg_err next cycle and stays in IDLE. start outside IDLE is ignored.
- FILL: in_ready=1, no loads. Each accepted pixel shifts s1<=s0, s0<=in_data, col++. After the 2nd pixel of the row, go to RUN.
- RUN: in_ready = !win_valid || win_ready.
  - On an accept: lpureg_enb=1 and lpureg_ld_wrn=1 combinationally in the same cycle, with di_0=s1, di_1=s0, di_2=in_data. Shift regs update and col++.
  - win_valid rises the next cycle; the register's data is valid then (1-cycle latency).
  - Simultaneous consume+accept keeps win_valid=1 and streams one window per cycle.
  - Consume without accept clears win_valid.
- Loads occur only on accept, so the register never overwrites an unconsumed window. lpureg_enb and lpureg_ld_wrn are 0 in every other cycle.
- Row end: accepting pixel col==row_len-1 does col<=0, s0/s1<=0, row++. No window ever spans two rows. Windows per row = row_len-2.
  - If more rows remain, go to FILL.
  - If this was the last row, the window loaded is flagged win_last, and the state goes to DRAIN.
- DRAIN: in_ready=0. When win_valid && win_ready, pulse done next cycle and go to IDLE.
- abort: from any state, next cycle state=IDLE, win_valid=0, counters cleared, no done. The register contents are left stale.
- Async reset mid-frame: same as abort, immediate.
- Counters are CNT_W bits wide. Legal cfg never wraps them.

Optional Feature:
ACCEL_LPUCTRL_STALL_CNT_EN
- Defined: adds output stall_cnt (16 bits).
  - Increments each cycle win_valid && !win_ready.
  - Saturates at 0xFFFF.
  - Clears on accepted start and on reset.
- Undefined: port and counter absent. All other behaviour identical.

Test Plan:
- row_len=5, rows=1, pixels 1..5, win_ready=1 -> loads of (1,2,3),(2,3,4),(3,4,5) on di_0..2. One window per cycle after fill. win_last with (3,4,5). done pulses 1 cycle after its consume.
- Same frame, win_ready=0 for 4 cycles after the first window -> in_ready=0, no further lpureg_enb, window (1,2,3) held. Resumes without loss or duplication.
- row_len=4, rows=2, pixels 10..17 -> windows (10,11,12),(11,12,13),(14,15,16),(15,16,17). No window containing 13 and 14 together.
- start with row_len=2, or with rows=0 -> cfg_err pulse, busy stays 0, in_ready stays 0.
- abort mid-row 1 of a 3-row frame, then a new start with row_len=3, rows=1 and pixels 7,8,9 -> single window (7,8,9) with win_last. Repeat with resetn pulse instead of abort -> same result.
- With ACCEL_LPUCTRL_STALL_CNT_EN: 6 backpressure cycles -> stall_cnt=6. Next accepted start -> stall_cnt=0.
